// File: rtl/mnacidpro_pkg.sv
// Shared types and constants for the microfluidic nucleic-acid prep sequencer:
// step states, valve bit positions, the per-state open-valve table and the
// peristaltic pump phase patterns.
package mnacidpro_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_BEAD_LOAD = 3'd1,
        ST_LYSIS     = 3'd2,
        ST_WASH      = 3'd3,
        ST_ELUTE     = 3'd4,
        ST_COLLECT   = 3'd5,
        ST_FLUSH     = 3'd6,
        ST_DONE      = 3'd7
    } state_e;

    localparam int VALVE_W = 11;

    localparam int V_COLLECT   = 0;
    localparam int V_BEAD_TRAP = 1;
    localparam int V_LOOP_EXIT = 2;
    localparam int V_BEAD      = 3;
    localparam int V_WASTE     = 4;
    localparam int V_HORIZ     = 5;
    localparam int V_VERTICAL  = 6;
    localparam int V_DEAD_END  = 7;
    localparam int V_ELUTE     = 8;
    localparam int V_WASH      = 9;
    localparam int V_LYSIS     = 10;

    localparam logic [VALVE_W-1:0] VALVE_ALL_CLOSED = '1;

    // Valves that are open (driven 0) in each state, indexed by state_e.
    localparam logic [VALVE_W-1:0] VALVE_OPEN [8] = '{
        11'd0,
        (11'd1 << V_BEAD)      | (11'd1 << V_BEAD_TRAP) | (11'd1 << V_HORIZ),
        (11'd1 << V_LYSIS)     | (11'd1 << V_VERTICAL)  | (11'd1 << V_BEAD_TRAP),
        (11'd1 << V_WASH)      | (11'd1 << V_HORIZ)     | (11'd1 << V_WASTE),
        (11'd1 << V_ELUTE)     | (11'd1 << V_LOOP_EXIT) | (11'd1 << V_DEAD_END),
        (11'd1 << V_LOOP_EXIT) | (11'd1 << V_COLLECT),
        (11'd1 << V_WASTE)     | (11'd1 << V_VERTICAL)  | (11'd1 << V_HORIZ),
        11'd0
    };

    localparam logic [2:0] PUMP_OFF = 3'b111;
    localparam logic [2:0] PUMP_PH0 = 3'b110;
    localparam logic [2:0] PUMP_PH1 = 3'b101;
    localparam logic [2:0] PUMP_PH2 = 3'b011;

    function automatic logic [VALVE_W-1:0] valveDrive(input state_e s);
        return ~VALVE_OPEN[s];
    endfunction

    function automatic logic isActive(input state_e s);
        return (s != ST_IDLE) && (s != ST_DONE);
    endfunction

    function automatic logic [2:0] pumpPattern(input logic [1:0] phase);
        logic [2:0] p;
        case (phase)
            2'd0:    p = PUMP_PH0;
            2'd1:    p = PUMP_PH1;
            2'd2:    p = PUMP_PH2;
            default: p = PUMP_OFF;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/mnacidpro_if.sv
// Control/status bundle between the run controller (master) and the
// sequencer (slave): run commands, latched step durations and valve drives.
interface mnacidpro_if #(
    parameter int SIZE  = 7,
    parameter int CNT_W = 16
);
    localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;

    logic             start_i;
    logic             abort_i;
    logic             hold_i;
    logic [CNT_W-1:0] t_load_i;
    logic [CNT_W-1:0] t_lysis_i;
    logic [CNT_W-1:0] t_wash_i;
    logic [CNT_W-1:0] t_elute_i;
    logic [CNT_W-1:0] t_collect_i;
    logic [CNT_W-1:0] t_flush_i;
    logic [CNT_W-1:0] pump_div_i;
    logic [10:0]      valve_ctrl_o;
    logic [2:0]       pump_o;
    logic [SIZE-1:0]  collect_mask_o;
    logic [IDX_W-1:0] sample_idx_o;
    logic             busy_o;
    logic             done_o;

    modport master (
        output start_i, abort_i, hold_i,
        output t_load_i, t_lysis_i, t_wash_i, t_elute_i, t_collect_i, t_flush_i, pump_div_i,
        input  valve_ctrl_o, pump_o, collect_mask_o, sample_idx_o, busy_o, done_o
    );

    modport slave (
        input  start_i, abort_i, hold_i,
        input  t_load_i, t_lysis_i, t_wash_i, t_elute_i, t_collect_i, t_flush_i, pump_div_i,
        output valve_ctrl_o, pump_o, collect_mask_o, sample_idx_o, busy_o, done_o
    );
endinterface

// File: rtl/mnacidpro_pump_phase.sv
// Three-phase peristaltic pump drive. The phase advances once every (div+1)
// enabled cycles and is held (output all-closed) while disabled; clear
// restarts the sequence so a new run always begins on the first phase.
module mnacidpro_pump_phase #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [CNT_W-1:0] div_i,
    output logic [2:0]       pump_o
);
    import mnacidpro_pkg::*;

    logic [1:0]       phase_q, phase_d, phaseCur;
    logic [CNT_W-1:0] cnt_q, cnt_d, cntCur;
    logic [2:0]       pump_q, pump_d;

    // Pick the pattern for the coming cycle and step the divider/phase.
    always_comb begin
        phaseCur = clear_i ? 2'd0 : phase_q;
        cntCur   = clear_i ? '0 : cnt_q;
        phase_d  = phaseCur;
        cnt_d    = cntCur;
        pump_d   = PUMP_OFF;
        if (enable_i) begin
            pump_d = pumpPattern(phaseCur);
            if (cntCur == div_i) begin
                cnt_d   = '0;
                phase_d = (phaseCur == 2'd2) ? 2'd0 : phaseCur + 2'd1;
            end else begin
                cnt_d = cntCur + CNT_W'(1);
            end
        end
    end

    // Phase, divider and registered pump drive.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q <= 2'd0;
            cnt_q   <= '0;
            pump_q  <= PUMP_OFF;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            pump_q  <= pump_d;
        end
    end

    assign pump_o = pump_q;

endmodule

// File: rtl/mnacidpro_sequencer.sv
// Step sequencer for the bead-based extraction chip: loads beads, lyses,
// washes, elutes and collects one sample per outlet, flushing between
// samples. Durations are captured at start so a run is immune to input edits.
module mnacidpro_sequencer #(
    parameter int SIZE  = 7,
    parameter int CNT_W = 16
) (
    input logic        clk,
    input logic        rst_n,
    mnacidpro_if.slave bus
);
    import mnacidpro_pkg::*;

    localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             abortFlag_q, abortFlag_d;
    logic [CNT_W-1:0] tLoad_q, tLysis_q, tWash_q, tElute_q, tCollect_q, tFlush_q, pumpDiv_q;
    logic [10:0]      valve_q;
    logic [SIZE-1:0]  mask_q;
    logic             busy_q, done_q;
    logic             startAcc, frozen, pumpEnable;
    logic [CNT_W-1:0] divEff;
    logic [2:0]       pumpDrive;

    // Next step, timer, sample index and abort flag; abort overrides hold.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        idx_d       = idx_q;
        abortFlag_d = abortFlag_q;
        startAcc    = 1'b0;
        frozen      = isActive(state_q) && bus.hold_i && !bus.abort_i;
        if (state_q == ST_IDLE) begin
            if (bus.start_i) begin
                startAcc    = 1'b1;
                state_d     = ST_BEAD_LOAD;
                timer_d     = bus.t_load_i;
                idx_d       = '0;
                abortFlag_d = 1'b0;
            end
        end else if (state_q == ST_DONE) begin
            state_d = ST_IDLE;
        end else if (bus.abort_i && (state_q != ST_FLUSH)) begin
            abortFlag_d = 1'b1;
            state_d     = ST_FLUSH;
            timer_d     = tFlush_q;
        end else begin
            if (bus.abort_i) begin
                abortFlag_d = 1'b1;
            end
            if (!frozen) begin
                if (timer_q != '0) begin
                    timer_d = timer_q - CNT_W'(1);
                end else begin
                    case (state_q)
                        ST_BEAD_LOAD: begin state_d = ST_LYSIS;   timer_d = tLysis_q;   end
                        ST_LYSIS:     begin state_d = ST_WASH;    timer_d = tWash_q;    end
                        ST_WASH:      begin state_d = ST_ELUTE;   timer_d = tElute_q;   end
                        ST_ELUTE:     begin state_d = ST_COLLECT; timer_d = tCollect_q; end
                        ST_COLLECT:   begin state_d = ST_FLUSH;   timer_d = tFlush_q;   end
                        default: begin
                            if ((idx_q == LAST_IDX) || abortFlag_q || bus.abort_i) begin
                                state_d = ST_DONE;
                                timer_d = '0;
                            end else begin
                                idx_d   = idx_q + IDX_W'(1);
                                state_d = ST_BEAD_LOAD;
                                timer_d = tLoad_q;
                            end
                        end
                    endcase
                end
            end
        end
    end

    assign pumpEnable = isActive(state_d) && !frozen;
    assign divEff     = startAcc ? bus.pump_div_i : pumpDiv_q;

    // State, captured durations and all registered outputs, derived from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            idx_q       <= '0;
            abortFlag_q <= 1'b0;
            tLoad_q     <= '0;
            tLysis_q    <= '0;
            tWash_q     <= '0;
            tElute_q    <= '0;
            tCollect_q  <= '0;
            tFlush_q    <= '0;
            pumpDiv_q   <= '0;
            valve_q     <= VALVE_ALL_CLOSED;
            mask_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            idx_q       <= idx_d;
            abortFlag_q <= abortFlag_d;
            if (startAcc) begin
                tLoad_q    <= bus.t_load_i;
                tLysis_q   <= bus.t_lysis_i;
                tWash_q    <= bus.t_wash_i;
                tElute_q   <= bus.t_elute_i;
                tCollect_q <= bus.t_collect_i;
                tFlush_q   <= bus.t_flush_i;
                pumpDiv_q  <= bus.pump_div_i;
            end
            valve_q <= valveDrive(state_d);
            mask_q  <= (state_d == ST_COLLECT) ? (SIZE'(1) << idx_d) : '0;
            busy_q  <= isActive(state_d);
            done_q  <= (state_d == ST_DONE);
        end
    end

    mnacidpro_pump_phase #(.CNT_W(CNT_W)) u_pump (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (startAcc),
        .enable_i (pumpEnable),
        .div_i    (divEff),
        .pump_o   (pumpDrive)
    );

    assign bus.valve_ctrl_o   = valve_q;
    assign bus.pump_o         = pumpDrive;
    assign bus.collect_mask_o = mask_q;
    assign bus.sample_idx_o   = idx_q;
    assign bus.busy_o         = busy_q;
    assign bus.done_o         = done_q;

endmodule

// File: doc/mnacidpro_sequencer.md
MNACIDPRO_SEQUENCER -- requirements
Module: mnacidpro_sequencer

Interface
REQ-001 Parameter SIZE, default 7, is the number of collect outlets, i.e. the number of samples per run.
REQ-002 Parameter CNT_W, default 16, is the width of the step-duration and pump-divider inputs.
REQ-003 clk  in  1  Single system clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  Synchronous, active-low reset.
REQ-005 start  in  1  Begins a run; honoured only in IDLE.
REQ-006 abort  in  1  Ends a run early; the chip is flushed first.
REQ-007 hold  in  1  Pauses the run: state, timer and pump phase freeze.
REQ-008 t_load, t_lysis, t_wash, t_elute, t_collect, t_flush  in  CNT_W each  Step durations; a step lasts (T+1) cycles.
REQ-009 pump_div  in  CNT_W  Pump phase advances every (pump_div+1) non-held pumping cycles.
REQ-010 valve_ctrl  out  11  Valve drive, 1 = closed, in bit order [10:0] = lysis, wash, elute, dead_end, vertical, horiz, waste, bead, loop_exit, bead_trap, collect.
REQ-011 pump  out  3  Peristaltic pump valve drive, 1 = closed.
REQ-012 collect_mask  out  SIZE  One-hot of sample_idx during COLLECT; zero in all other states.
REQ-013 sample_idx  out  clog2(SIZE)  Index of the current sample.
REQ-014 busy  out  1  High in BEAD_LOAD through FLUSH.
REQ-015 done  out  1  One-cycle pulse at the end of a run.

Function
REQ-016 States and the valves open in each; all other valves are closed:
- IDLE: none.
- BEAD_LOAD: bead, bead_trap, horiz.
- LYSIS: lysis, vertical, bead_trap.
- WASH: wash, horiz, waste.
- ELUTE: elute, loop_exit, dead_end.
- COLLECT: loop_exit, collect.
- FLUSH: waste, vertical, horiz.
- DONE: none.
REQ-017 Step sequence: IDLE -start-> BEAD_LOAD -> LYSIS -> WASH -> ELUTE -> COLLECT -> FLUSH.
REQ-018 From FLUSH: go to DONE if sample_idx==SIZE-1 or the abort flag is set; otherwise increment sample_idx and go to BEAD_LOAD.
REQ-019 DONE lasts exactly one cycle with done=1, then returns to IDLE.
REQ-020 All six durations and pump_div are latched on the accepted start; input changes during a run have no effect.
REQ-021 Step timer: loaded with the latched T on step entry and decremented each non-held cycle; the step ends in the cycle the timer reads 0, so T=0 gives a one-cycle step.
REQ-022 Pump in active states steps through the sequence 110 -> 101 -> 011 -> 110 ...
  - The first cycle of a run outputs 110.
  - The phase continues across step boundaries and is not reset per step.
REQ-023 Pump outputs 111 in IDLE, DONE, and any cycle where hold=1.
REQ-024 hold=1 freezes state, timer, pump phase and its divider; valve_ctrl keeps its current value; hold has no effect in IDLE.
REQ-025 abort in an active state other than FLUSH sets the abort flag and enters FLUSH next cycle with its timer loaded with t_flush.
REQ-026 abort during FLUSH only sets the flag; abort in IDLE or DONE is ignored.
REQ-027 When abort and hold are high together, abort wins.
REQ-028 start while busy is ignored; start held high through DONE re-launches only after IDLE has been visited for one cycle.
REQ-029 sample_idx resets to 0 on each accepted start and holds its last value in IDLE.
REQ-030 All outputs are registered; valve_ctrl and pump change in the same cycle the state changes.

Reset
REQ-031 rst_n=0 at a clock edge forces IDLE with:
- valve_ctrl=11'h7FF, pump=3'b111;
- collect_mask=0, sample_idx=0, busy=0, done=0;
- abort flag, timer and pump phase cleared.
REQ-032 Reset mid-run abandons the run without a FLUSH step and without a done pulse.

Structure
REQ-033 A shared package mnacidpro_pkg holds:
- the state enum;
- valve bit-index constants;
- the per-state valve-open table;
- the pump phase constants.
REQ-034 The pump phase generator is a sub-module mnacidpro_pump_phase, with inputs enable and div and output pump[2:0].

Verification
REQ-035 SIZE=2, all T=1, pump_div=0, start pulse -> busy high for 24 cycles; states visited twice in order; done pulses once at cycle 25; sample_idx goes 0 then 1.
REQ-036 Same setup -> pump sequence 110, 101, 011, repeating every cycle; valve_ctrl=11'h7FF with pump=111 in IDLE and DONE; collect_mask=2'b01 then 2'b10, only in the COLLECT steps.
REQ-037 abort in the first WASH cycle of sample 0 (t_flush=3) -> FLUSH lasts 4 cycles, then DONE with done=1; sample_idx stays 0.
REQ-038 hold high for 5 cycles mid-LYSIS -> pump=111 and state frozen during hold; LYSIS total duration becomes T+1+5 cycles; pump phase resumes where it stopped.
REQ-039 rst_n low during ELUTE -> next cycle IDLE, all reset values; no done pulse.
REQ-040 Change t_wash and assert start during a run -> no effect; the durations latched at the original start are used.
